// File: rtl/nvram_backup_ctrl.sv
// Save-RAM backup controller: loads a mounted image into NVRAM sector by
// sector, writes it back on request or after a quiet period of no writes.
`timescale 1ns/1ps
module nvram_backup_ctrl #(
   parameter int SECT_W = 4,
   parameter int QUIET_W = 24,
   parameter logic [QUIET_W-1:0] QUIET_CYC = 24'd10_000_000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        img_mounted,
   input  logic [31:0] img_size,
   input  logic        download,
   input  logic        save_req,
   input  logic        autosave_en,
   input  logic        nvram_we,
   input  logic        sd_ack,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic        bk_ena,
   output logic        bk_busy,
   output logic        bk_dirty,
   output logic        bk_reset
);

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   localparam logic [23:0] NSECT = 24'd1 << SECT_W;
   localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_CYC - QUIET_W'(1);

   state_t state;
   logic mnt_q, dl_q, sav_q, ack_q;
   logic mnt_edge, dl_edge, sav_edge, ack_rise, ack_fall;
   logic pending_load, pending_save, abort, load_mode, dirty;
   logic [SECT_W-1:0] lba, last, load_cnt, size_last;
   logic [QUIET_W-1:0] quiet_cnt;
   logic [23:0] nsec;

   assign mnt_edge = img_mounted & ~mnt_q;
   assign dl_edge  = download & ~dl_q;
   assign sav_edge = save_req & ~sav_q;
   assign ack_rise = sd_ack & ~ack_q;
   assign ack_fall = ~sd_ack & ack_q;

   // sector count of the image, rounded up, clamped to the NVRAM size
   assign nsec = {1'b0, img_size[31:9]} + {23'd0, |img_size[8:0]};
   assign size_last = (nsec >= NSECT) ? '1
                    : nsec[SECT_W-1:0] - SECT_W'(1);

   assign sd_lba   = {{(32-SECT_W){1'b0}}, lba};
   assign bk_busy  = (state != IDLE);
   assign bk_dirty = dirty;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         mnt_q        <= 1'b0;
         dl_q         <= 1'b0;
         sav_q        <= 1'b0;
         ack_q        <= 1'b0;
         pending_load <= 1'b0;
         pending_save <= 1'b0;
         abort        <= 1'b0;
         load_mode    <= 1'b0;
         dirty        <= 1'b0;
         lba          <= '0;
         last         <= '0;
         load_cnt     <= '0;
         quiet_cnt    <= '0;
         sd_rd        <= 1'b0;
         sd_wr        <= 1'b0;
         bk_ena       <= 1'b0;
         bk_reset     <= 1'b0;
      end else begin
         mnt_q    <= img_mounted;
         dl_q     <= download;
         sav_q    <= save_req;
         ack_q    <= sd_ack;
         bk_reset <= 1'b0;

         if (nvram_we || !dirty)
            quiet_cnt <= '0;
         else if (!(&quiet_cnt))
            quiet_cnt <= quiet_cnt + QUIET_W'(1);

         unique case (state)
            IDLE: begin
               abort <= 1'b0;
               if (bk_ena && (pending_load || pending_save) && !dl_edge) begin
                  lba       <= '0;
                  state     <= REQ;
                  load_mode <= pending_load;
                  if (pending_load) begin
                     last         <= load_cnt;
                     pending_load <= 1'b0;
                     sd_rd        <= 1'b1;
                  end else begin
                     last         <= '1;
                     pending_save <= 1'b0;
                     dirty        <= 1'b0;
                     sd_wr        <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (ack_rise) begin
                  sd_rd <= 1'b0;
                  sd_wr <= 1'b0;
                  state <= XFER;
               end
            end
            XFER: begin
               if (ack_fall) begin
                  if (lba == last || abort) begin
                     state <= IDLE;
                     abort <= 1'b0;
                     if (load_mode && !abort) begin
                        bk_reset <= 1'b1;
                        dirty    <= 1'b0;
                     end
                  end else begin
                     lba   <= lba + SECT_W'(1);
                     sd_rd <= load_mode;
                     sd_wr <= ~load_mode;
                     state <= REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (mnt_edge) begin
            if (|img_size) begin
               bk_ena       <= 1'b1;
               pending_load <= 1'b1;
               load_cnt     <= size_last;
            end else begin
               bk_ena <= 1'b0;
            end
         end

         if (sav_edge && bk_ena)
            pending_save <= 1'b1;
         if (quiet_cnt == QUIET_LAST && dirty && autosave_en && bk_ena && state == IDLE)
            pending_save <= 1'b1;

         // writes landing in a save re-dirty the image; load traffic does not
         if (nvram_we && !(load_mode && state != IDLE))
            dirty <= 1'b1;

         if (dl_edge) begin
            bk_ena       <= 1'b0;
            pending_load <= 1'b0;
            pending_save <= 1'b0;
            dirty        <= 1'b0;
            if (state != IDLE)
               abort <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nvram_backup_ctrl.sv
// Bench for nvram_backup_ctrl: random SD ack timing, sector lists derived
// from image size and request order.
`timescale 1ns/1ps
module tb_nvram_backup_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        img_mounted = 1'b0;
   logic [31:0] img_size = '0;
   logic        download = 1'b0;
   logic        save_req = 1'b0;
   logic        autosave_en = 1'b0;
   logic        nvram_we = 1'b0;
   logic        sd_ack = 1'b0;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, bk_ena, bk_busy, bk_dirty, bk_reset;

   nvram_backup_ctrl #(
      .SECT_W(4),
      .QUIET_W(24),
      .QUIET_CYC(24'd100)
   ) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .img_mounted(img_mounted),
      .img_size(img_size),
      .download(download),
      .save_req(save_req),
      .autosave_en(autosave_en),
      .nvram_we(nvram_we),
      .sd_ack(sd_ack),
      .sd_lba(sd_lba),
      .sd_rd(sd_rd),
      .sd_wr(sd_wr),
      .bk_ena(bk_ena),
      .bk_busy(bk_busy),
      .bk_dirty(bk_dirty),
      .bk_reset(bk_reset)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;
   logic [32:0] txq[$];
   int tx_base = 0;
   int rst_pulses = 0;
   int rst_base = 0;
   int both_req = 0;
   bit resp_busy = 1'b0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // sectors a load must fetch: image size rounded up to 512, capped at 16
   function automatic int exp_sectors(input logic [31:0] size);
      longint s;
      s = (longint'(size) + 511) / 512;
      return (s > 16) ? 16 : int'(s);
   endfunction

   function automatic int ntx();
      return txq.size() - tx_base;
   endfunction

   task automatic start_test();
      tx_base  = txq.size();
      rst_base = rst_pulses;
   endtask

   task automatic expect_seq(input string tag, input int n_rd, input int n_wr);
      logic [32:0] exp_q[$];
      for (int i = 0; i < n_rd; i++) exp_q.push_back({1'b0, 32'(i)});
      for (int i = 0; i < n_wr; i++) exp_q.push_back({1'b1, 32'(i)});
      check({tag, "_len"}, ntx(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < ntx(); i++)
         check($sformatf("%s_tx%0d", tag, i), txq[tx_base + i], exp_q[i]);
   endtask

   task automatic wait_ntx(input string tag, input int n);
      int cyc = 0;
      while (ntx() < n && cyc < 5000) begin
         @(negedge clk_sys);
         cyc++;
      end
      check({tag, "_timeout"}, cyc >= 5000, 0);
   endtask

   task automatic wait_txn(input string tag, input int n);
      int cyc = 0;
      while (!(ntx() >= n && !bk_busy && !resp_busy) && cyc < 20000) begin
         @(negedge clk_sys);
         cyc++;
      end
      check({tag, "_timeout"}, cyc >= 20000, 0);
      repeat (5) @(negedge clk_sys);
   endtask

   task automatic mount(input logic [31:0] size);
      @(negedge clk_sys);
      img_size = size;
      img_mounted = 1'b1;
      @(negedge clk_sys);
      img_mounted = 1'b0;
   endtask

   task automatic we_pulse();
      @(negedge clk_sys);
      nvram_we = 1'b1;
      @(negedge clk_sys);
      nvram_we = 1'b0;
   endtask

   task automatic save_pulse();
      @(negedge clk_sys);
      save_req = 1'b1;
      @(negedge clk_sys);
      save_req = 1'b0;
   endtask

   // SD side: log each request, then ack after a random delay
   initial begin
      forever begin
         @(negedge clk_sys);
         if (!reset && (sd_rd || sd_wr)) begin
            resp_busy = 1'b1;
            if (sd_rd && sd_wr) both_req++;
            txq.push_back({sd_wr, sd_lba});
            repeat ($urandom_range(1, 3)) @(negedge clk_sys);
            sd_ack = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk_sys);
            sd_ack = 1'b0;
            resp_busy = 1'b0;
         end
      end
   end

   always @(negedge clk_sys) if (bk_reset) rst_pulses++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] sizes[10];
      int n, cnt;
      bit wr;

      repeat (3) @(negedge clk_sys);
      check("rst_lba", sd_lba, 0);
      check("rst_rd", sd_rd, 0);
      check("rst_wr", sd_wr, 0);
      check("rst_ena", bk_ena, 0);
      check("rst_busy", bk_busy, 0);
      check("rst_dirty", bk_dirty, 0);
      check("rst_bkrst", bk_reset, 0);
      reset = 1'b0;
      @(negedge clk_sys);

      // full 8 KB load with request latency
      start_test();
      @(negedge clk_sys);
      img_size = 32'd8192;
      img_mounted = 1'b1;
      @(negedge clk_sys);
      img_mounted = 1'b0;
      check("lat_cyc1_rd", sd_rd, 0);
      @(negedge clk_sys);
      check("lat_cyc2_rd", sd_rd, 1);
      check("lat_cyc2_busy", bk_busy, 1);
      wait_txn("load8k", 16);
      expect_seq("load8k", 16, 0);
      check("load8k_pulses", rst_pulses - rst_base, 1);
      check("load8k_dirty", bk_dirty, 0);
      check("load8k_ena", bk_ena, 1);
      check("load8k_busy", bk_busy, 0);

      // boundary and random image sizes
      sizes = '{32'd1000, 32'd1, 32'd511, 32'd512, 32'd513, 32'd7680,
                32'd8193, 32'hFFFF_FFFF, 32'd0, 32'd0};
      sizes[8] = $urandom_range(1, 20000);
      sizes[9] = $urandom | 32'd1;
      foreach (sizes[k]) begin
         start_test();
         mount(sizes[k]);
         wait_ntx($sformatf("sz%0d_first", k), 1);
         if ($urandom_range(0, 1) == 1) we_pulse();
         n = exp_sectors(sizes[k]);
         wait_txn($sformatf("sz%0d", k), n);
         expect_seq($sformatf("sz%0d", k), n, 0);
         check($sformatf("sz%0d_pulses", k), rst_pulses - rst_base, 1);
         check($sformatf("sz%0d_dirty", k), bk_dirty, 0);
      end

      // zero-size mount disables backup
      start_test();
      mount(32'd0);
      repeat (5) @(negedge clk_sys);
      check("zero_ena", bk_ena, 0);
      save_pulse();
      repeat (20) @(negedge clk_sys);
      check("zero_nosave", ntx(), 0);
      check("zero_busy", bk_busy, 0);

      // manual save, optional write during it
      start_test();
      mount(32'd8192);
      wait_txn("reload", 16);
      check("reload_len", ntx(), 16);
      start_test();
      we_pulse();
      check("we_dirty", bk_dirty, 1);
      save_pulse();
      wait_ntx("save_first", 2);
      wr = 1'($urandom_range(0, 1));
      if (wr) we_pulse();
      wait_txn("save", 16);
      expect_seq("save", 0, 16);
      check("save_pulses", rst_pulses - rst_base, 0);
      check("save_busy", bk_busy, 0);
      check("save_dirty", bk_dirty, wr);

      // autosave disabled: dirty stays, nothing written
      start_test();
      autosave_en = 1'b0;
      we_pulse();
      repeat (300) @(negedge clk_sys);
      check("noauto_tx", ntx(), 0);
      check("noauto_dirty", bk_dirty, 1);

      // autosave after quiet period
      autosave_en = 1'b1;
      start_test();
      for (int k = 0; k < 6; k++) begin
         we_pulse();
         if (k < 5) repeat (49) @(negedge clk_sys);
      end
      check("auto_quiet_tx", ntx(), 0);
      cnt = 0;
      while (!sd_wr && cnt < 300) begin
         @(negedge clk_sys);
         cnt++;
      end
      check("auto_lat_window", cnt >= 100 && cnt <= 102, 1);
      wait_txn("auto", 16);
      expect_seq("auto", 0, 16);
      check("auto_dirty", bk_dirty, 0);
      autosave_en = 1'b0;

      // save request during a load is serviced right after it
      start_test();
      mount(32'd8192);
      wait_ntx("ldsv_mid", 3);
      save_pulse();
      wait_txn("ldsv", 32);
      expect_seq("ldsv", 16, 16);
      check("ldsv_pulses", rst_pulses - rst_base, 1);
      check("ldsv_dirty", bk_dirty, 0);

      // download aborts a load after the current sector
      start_test();
      mount(32'd8192);
      wait_ntx("abort_mid", 6);
      download = 1'b1;
      @(negedge clk_sys);
      download = 1'b0;
      wait_txn("abort", 6);
      expect_seq("abort", 6, 0);
      check("abort_pulses", rst_pulses - rst_base, 0);
      check("abort_ena", bk_ena, 0);
      check("abort_dirty", bk_dirty, 0);
      save_pulse();
      repeat (40) @(negedge clk_sys);
      check("abort_nosave", ntx(), 6);
      check("abort_busy", bk_busy, 0);

      // reset in the middle of a transfer
      start_test();
      mount(32'd8192);
      wait_ntx("rstmid", 3);
      reset = 1'b1;
      #1;
      check("rstmid_rd", sd_rd, 0);
      check("rstmid_wr", sd_wr, 0);
      check("rstmid_busy", bk_busy, 0);
      check("rstmid_ena", bk_ena, 0);
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (30) @(negedge clk_sys);
      check("rstmid_tx", ntx(), 3);

      check("never_rd_and_wr", both_req, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
